magic_nor_sequencer: RTL

// - Executes a mapped nor2/inv1 gate list as a MAGIC crossbar would, i.e. consumes the netlists our ABC flow emits.
// - Emulates a 1-D memristive row: a bit-cell array, with each gate run as INIT(dst=1) then EVAL.
// - Host loads the primary inputs, streams gate instructions, then reads back the output bit and cycle/gate statistics.
// - Sits between the netlist-to-microcode converter and the cost/latency checker of the flow.

---
 rtl/magic_nor_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/magic_nor_sequencer.sv
// MAGIC NOR/INV gate-list sequencer over a 1-D memristive bit-cell row.
// Each gate runs as INIT (dst=1) then EVAL; counters report cost.
module magic_nor_sequencer #(
    parameter int NUM_IN = 10,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_IN-1:0] in_vec,
    output logic              busy,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_a,
    input  logic [ADDR_W-1:0] instr_b,
    input  logic [ADDR_W-1:0] instr_dst,
    input  logic              instr_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_data,
    output logic              res_err,
    output logic [CNT_W-1:0]  res_cycles,
    output logic [CNT_W-1:0]  res_gates
);

    localparam int NCELL = 2 ** ADDR_W;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_INV = 2'b01;
    localparam logic [1:0] OP_NOR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam logic [ADDR_W-1:0] IN_LIM = ADDR_W'(NUM_IN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_INIT,
        S_EVAL,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [NCELL-1:0]  cells_q, cells_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [ADDR_W-1:0] b_q, b_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [CNT_W-1:0]  gates_q, gates_d;
    logic              rejected;
    logic              aliased;
    logic [CNT_W-1:0]  cycles_inc;
    logic [CNT_W-1:0]  gates_inc;

    assign cycles_inc = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + CNT_ONE;
    assign gates_inc  = (gates_q == CNT_MAX) ? gates_q : gates_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        cells_d     = cells_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        dst_d       = dst_q;
        last_d      = last_q;
        err_d       = err_q;
        cycles_d    = cycles_q;
        gates_d     = gates_q;
        instr_ready = 1'b0;
        rejected    = 1'b0;
        aliased     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cells_d[NUM_IN-1:0] = in_vec;
                    cycles_d = '0;
                    gates_d  = '0;
                    err_d    = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_ready = 1'b1;
                cycles_d    = cycles_inc;
                if (instr_valid) begin
                    op_d     = instr_op;
                    a_d      = instr_a;
                    b_d      = instr_b;
                    dst_d    = instr_dst;
                    last_d   = instr_last;
                    rejected = (instr_op == OP_RSV) || (instr_dst < IN_LIM);
                    if (rejected) begin
                        err_d = 1'b1;
                    end
                    if (rejected || instr_op == OP_NOP) begin
                        state_d = instr_last ? S_DONE : S_FETCH;
                    end else begin
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: begin
                cycles_d       = cycles_inc;
                cells_d[dst_q] = 1'b1;
                state_d        = S_EVAL;
            end
            S_EVAL: begin
                cycles_d = cycles_inc;
                gates_d  = gates_inc;
                // Operands come from the post-INIT row, so aliasing reads the 1
                aliased  = (a_q == dst_q) || ((op_q == OP_NOR) && (b_q == dst_q));
                if (aliased) begin
                    err_d = 1'b1;
                end
                if (op_q == OP_INV) begin
                    cells_d[dst_q] = ~cells_q[a_q];
                end else begin
                    cells_d[dst_q] = ~(cells_q[a_q] | cells_q[b_q]);
                end
                state_d = last_q ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cells_q  <= '0;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            dst_q    <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            cycles_q <= '0;
            gates_q  <= '0;
        end else begin
            state_q  <= state_d;
            cells_q  <= cells_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dst_q    <= dst_d;
            last_q   <= last_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
            gates_q  <= gates_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign res_valid  = (state_q == S_DONE);
    assign res_data   = res_valid & cells_q[dst_q];
    assign res_err    = err_q;
    assign res_cycles = cycles_q;
    assign res_gates  = gates_q;

endmodule
